// File: rtl/alu_pkg.sv
// Shared encodings for the bitwise logic unit: operation select, FSM states,
// and the single-bit operation used by every digit slice.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_NOR = 2'd2,
        OP_XOR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic bit_op(input logic a, input logic b, input op_e o);
        logic r;
        case (o)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_digit.sv
// Purely combinational DIGIT-bit slice of the bitwise logic unit; the same
// slice serves a full-width ALU when instantiated with DIGIT = WIDTH.
module logic_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] in1,
    input  logic [DIGIT-1:0] in2,
    input  op_e              op,
    output logic [DIGIT-1:0] out
);

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_bit
            assign out[gi] = bit_op(in1[gi], in2[gi], op);
        end
    endgenerate

endmodule

// File: rtl/logic_serial_unit.sv
// Digit-serial bitwise logic unit: latches two operands, processes DIGIT bits
// per cycle LSB-first, and holds the full result until the consumer takes it.
module logic_serial_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic             zero
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NDIG - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    op_e              op_q, op_d;
    logic [DIGIT-1:0] digit_res;
    logic [WIDTH-1:0] result_shift;

    logic_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .in1(a_q[DIGIT-1:0]),
        .in2(b_q[DIGIT-1:0]),
        .op (op_q),
        .out(digit_res)
    );

    // New digit enters at the top so that after NDIG shifts the first digit
    // computed sits in the least significant position.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign result_shift = digit_res;
        end else begin : g_multi
            assign result_shift = {digit_res, result_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in1;
                    b_d     = in2;
                    op_d    = op_e'(op);
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                result_d = result_shift;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out1      = result_q;
    assign zero      = out_valid && (result_q == '0);

endmodule

// File: tb/tb_logic_serial_unit.sv
// Self-checking bench for logic_serial_unit: directed cases plus randomized
// operations, compared every cycle against a transaction-level model.
module tb_logic_serial_unit;

    localparam int W = 32;
    localparam int D = 4;
    localparam int N = W / D;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out1;
    logic         zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_serial_unit #(
        .WIDTH(W),
        .DIGIT(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out1     (out1),
        .zero     (zero)
    );

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] o);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction-level model: a result becomes visible N edges after the
    // accepting edge and stays until a handshake.
    bit           m_idle  = 1'b1;
    int           m_age   = 0;
    logic [W-1:0] m_exp   = '0;
    bit           m_fresh = 1'b1;
    bit           cmp_en  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_idle  = 1'b1;
            m_age   = 0;
            m_exp   = '0;
            m_fresh = 1'b1;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle  = 1'b0;
                m_age   = 0;
                m_exp   = ref_op(in1, in2, op);
                m_fresh = 1'b0;
            end
        end else if (m_age == N) begin
            if (out_ready) m_idle = 1'b1;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit m_valid;
            m_valid = !m_idle && (m_age == N);
            chk("model_in_ready", in_ready, m_idle);
            chk("model_out_valid", out_valid, m_valid);
            chk("model_zero", zero, m_valid && (m_exp == '0));
            if (m_valid) chk("model_out1", out1, m_exp);
            if (m_fresh) chk("model_out1_after_reset", out1, '0);
        end
    end

    // Called and returns on a falling edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o,
                          input int stall, output logic [W-1:0] res, output logic z,
                          output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", in_ready, 1);
        in_valid  = 1'b1;
        in1       = a;
        in2       = b;
        op        = o;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            in1       = $urandom;
            in2       = $urandom;
            op        = 2'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        out_ready = (stall == 0);
        chk("result_latency", lat, N);
        res = out1;
        z   = zero;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_out1", out1, res);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_handshake", in_ready, 1);
        out_ready = 1'b0;
        $display("op=%0d a=%h b=%h -> out1=%h zero=%0b lat=%0d stall=%0d", o, a, b, res, z, lat, stall);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] res;
        logic         z;
        int           lat;
        int           last;
        int           nres;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = '0;
        in2       = '0;
        op        = 2'd0;
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out1", out1, '0);
        chk("reset_zero", zero, 0);

        run_op(32'h0000_0000, 32'h0000_0000, 2'd2, 0, res, z, lat);
        chk("nor_out1", res, 32'hFFFF_FFFF);
        chk("nor_zero", z, 0);
        chk("nor_latency", lat, 8);

        run_op(32'hA5A5_A5A5, 32'hFFFF_0000, 2'd3, 0, res, z, lat);
        chk("xor_out1", res, 32'h5A5A_A5A5);
        chk("xor_zero", z, 0);

        run_op(32'h0F0F_0F0F, 32'hF0F0_F0F0, 2'd0, 0, res, z, lat);
        chk("and_out1", res, 32'h0000_0000);
        chk("and_zero", z, 1);

        run_op(32'h1234_0000, 32'h0000_5678, 2'd1, 5, res, z, lat);
        chk("or_out1", res, 32'h1234_5678);
        chk("or_zero", z, 0);

        // Reset during the 4th BUSY cycle discards the operation.
        in_valid = 1'b1;
        in1      = 32'hDEAD_BEEF;
        in2      = 32'h1357_9BDF;
        op       = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midbusy_rst_in_ready", in_ready, 1);
        chk("midbusy_rst_out_valid", out_valid, 0);
        chk("midbusy_rst_out1", out1, '0);
        chk("midbusy_rst_zero", zero, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_stale_result", out_valid, 0);
        end
        out_ready = 1'b0;
        $display("reset mid-BUSY: operation discarded");

        // Continuous in_valid with an always-ready consumer.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        last      = -1;
        nres      = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            in1 = $urandom;
            in2 = $urandom;
            op  = 2'($urandom);
            @(negedge clk);
            if (out_valid) begin
                if (last >= 0) chk("b2b_period", cyc - last, 10);
                $display("back-to-back result %0d at cycle %0d out1=%h", nres, cyc, out1);
                last = cyc;
                nres++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", nres, 6);
        repeat (12) @(negedge clk);
        out_ready = 1'b0;

        for (int t = 0; t < 150; t++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [1:0]   o;
            a = $urandom;
            b = $urandom;
            o = 2'($urandom);
            if (t % 10 == 0) b = ~a;
            run_op(a, b, o, int'($urandom_range(0, 3)), res, z, lat);
            chk("rand_out1", res, ref_op(a, b, o));
            chk("rand_zero", z, ref_op(a, b, o) == '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
